// File: rtl/moore_101_detector.sv
`default_nettype none
// ============================================================================
// Module      : moore_101_detector
// Description : Moore FSM that detects the serial pattern 1-0-1 on a
//               single-bit stream qualified by din_valid. dout is decoded
//               from the state register only. A saturating counter records
//               how many times the FSM has entered the match state.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   OVERLAP   - 1: the trailing 1 of a match seeds the next match
//               0: a match consumes all of its bits
//   COUNT_W   - width of det_count
// Ports:
//   clk       in   1        rising-edge clock
//   rst       in   1        synchronous active-high reset (beats din_valid)
//   din       in   1        serial data bit
//   din_valid in   1        qualifier; 0 holds state and det_count
//   dout      out  1        high exactly while the FSM is in S101
//   state     out  2        current state encoding
//   det_count out  COUNT_W  entries into S101 since reset, saturating
// ============================================================================
module moore_101_detector #(
   parameter int OVERLAP = 1,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               din,
   input  logic               din_valid,
   output logic               dout,
   output logic [1:0]         state,
   output logic [COUNT_W-1:0] det_count
);

   typedef enum logic [1:0] {
      S0   = 2'b00,   // idle
      S1   = 2'b01,   // seen "1"
      S10  = 2'b10,   // seen "10"
      S101 = 2'b11    // match
   } state_t;

   localparam logic [COUNT_W-1:0] C_COUNT_MAX = {COUNT_W{1'b1}};

   state_t             r_state;
   state_t             w_next_state;
   logic [COUNT_W-1:0] r_count;
   logic [COUNT_W-1:0] w_next_count;

   // ------------------------------------------------------------------------
   // State and counter registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S0;
         r_count <= '0;
      end else begin
         r_state <= w_next_state;
         r_count <= w_next_count;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and counter logic. Without din_valid everything holds.
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_next_count = r_count;

      if (din_valid) begin
         case (r_state)
            S0:  w_next_state = din ? S1 : S0;
            // A repeated 1 is itself a fresh prefix, so stay in S1.
            S1:  w_next_state = din ? S1 : S10;
            S10: w_next_state = din ? S101 : S0;
            S101: begin
               if (OVERLAP != 0) begin
                  // The matched trailing 1 already counts as a leading 1.
                  w_next_state = din ? S1 : S10;
               end else begin
                  w_next_state = din ? S1 : S0;
               end
            end
            default: w_next_state = S0;
         endcase

         // Count entries into S101, including S101 -> S101 is impossible,
         // so every valid edge landing in S101 is a new match.
         if ((w_next_state == S101) && (r_count != C_COUNT_MAX)) begin
            w_next_count = r_count + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: pure Moore decode of registered state
   // ------------------------------------------------------------------------
   assign dout      = (r_state == S101);
   assign state     = r_state;
   assign det_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_moore_101_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_moore_101_detector
// Description : Directed self-checking bench. Two detectors share one input
//               stream: u_ovl (OVERLAP=1, COUNT_W=8) and u_novl (OVERLAP=0,
//               COUNT_W=3, so its counter saturates at 7).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_101_detector;

   logic       clk;
   logic       rst;
   logic       din;
   logic       din_valid;

   logic       dout_a;
   logic [1:0] state_a;
   logic [7:0] count_a;
   logic       dout_b;
   logic [1:0] state_b;
   logic [2:0] count_b;

   int tests;
   int failed;

   moore_101_detector #(.OVERLAP(1), .COUNT_W(8)) u_ovl (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .dout      (dout_a),
      .state     (state_a),
      .det_count (count_a)
   );

   moore_101_detector #(.OVERLAP(0), .COUNT_W(3)) u_novl (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .dout      (dout_b),
      .state     (state_b),
      .det_count (count_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs, take one rising edge, then settle 1 time unit.
   task automatic step(input logic r, input logic v, input logic d);
      rst       = r;
      din_valid = v;
      din       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests     = 0;
      failed    = 0;
      rst       = 1'b1;
      din       = 1'b0;
      din_valid = 1'b1;
      #2;

      // ---- Reset then idle zeros -------------------------------------------
      step(1, 1, 0);
      check("rst_state_a", state_a, 2'b00);
      check("rst_dout_a",  dout_a,  0);
      check("rst_count_a", count_a, 0);
      check("rst_count_b", count_b, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0);
      check("idle_state_a", state_a, 2'b00);
      check("idle_dout_a",  dout_a,  0);
      check("idle_count_a", count_a, 0);

      // ---- Basic 1,0,1 then continue 0,1 (overlap stream 1,0,1,0,1) -------
      step(0, 1, 1);
      check("b1_state_a", state_a, 2'b01);
      check("b1_dout_a",  dout_a,  0);
      step(0, 1, 0);
      check("b2_state_a", state_a, 2'b10);
      check("b2_dout_a",  dout_a,  0);
      step(0, 1, 1);
      check("b3_dout_a",  dout_a,  1);
      check("b3_dout_b",  dout_b,  1);
      check("b3_count_a", count_a, 1);
      check("b3_count_b", count_b, 1);
      step(0, 1, 0);
      check("o4_dout_a",  dout_a,  0);
      check("o4_state_a", state_a, 2'b10);
      check("o4_state_b", state_b, 2'b00);
      step(0, 1, 1);
      check("o5_dout_a",  dout_a,  1);
      check("o5_count_a", count_a, 2);
      check("o5_dout_b",  dout_b,  0);
      check("o5_state_b", state_b, 2'b01);
      check("o5_count_b", count_b, 1);

      // ---- Near miss 1,1,0,1 ------------------------------------------------
      step(1, 1, 0);
      step(0, 1, 1);
      step(0, 1, 1);
      check("nm1_state_a", state_a, 2'b01);
      step(0, 1, 0);
      check("nm1_dout_a3", dout_a, 0);
      step(0, 1, 1);
      check("nm1_dout_a4", dout_a, 1);
      check("nm1_count_a", count_a, 1);

      // ---- Near miss 1,0,0,1: never detects ---------------------------------
      step(1, 1, 0);
      step(0, 1, 1);
      check("nm2_dout1", dout_a, 0);
      step(0, 1, 0);
      check("nm2_dout2", dout_a, 0);
      step(0, 1, 0);
      check("nm2_state3", state_a, 2'b00);
      check("nm2_dout3", dout_a, 0);
      step(0, 1, 1);
      check("nm2_dout4", dout_a, 0);
      check("nm2_state4", state_a, 2'b01);
      check("nm2_count", count_a, 0);

      // ---- Valid gating ----------------------------------------------------
      step(1, 1, 0);
      step(0, 1, 1);
      step(0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0);
         check("gap_state_a", state_a, 2'b10);
      end
      step(0, 1, 1);
      check("resume_dout_a",  dout_a,  1);
      check("resume_count_a", count_a, 1);
      // Held in S101 with valid low: dout stays high, no extra count.
      step(0, 0, 0);
      step(0, 0, 1);
      check("hold_dout_a",  dout_a,  1);
      check("hold_count_a", count_a, 1);
      check("hold_dout_b",  dout_b,  1);

      // ---- Reset mid-pattern ------------------------------------------------
      step(1, 1, 0);
      step(0, 1, 1);
      step(0, 1, 0);
      step(1, 1, 1);
      check("midrst_state_a", state_a, 2'b00);
      check("midrst_dout_a",  dout_a,  0);
      check("midrst_count_a", count_a, 0);
      step(0, 1, 1);
      check("fresh_state_a", state_a, 2'b01);
      // Reset wins over din_valid=0.
      step(1, 0, 0);
      check("rst_over_valid", state_a, 2'b00);

      // ---- Saturation: 1 then (0,1) x 259 => 259 overlapped matches --------
      step(0, 1, 1);
      for (int i = 0; i < 255; i++) begin
         step(0, 1, 0);
         step(0, 1, 1);
      end
      check("sat255_count_a", count_a, 8'hFF);
      step(0, 1, 0);
      step(0, 1, 1);
      check("sat256_count_a", count_a, 8'hFF);
      check("sat256_dout_a",  dout_a,  1);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0);
         step(0, 1, 1);
      end
      check("sat259_count_a", count_a, 8'hFF);
      check("sat_count_b",    count_b, 3'h7);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
